// File: rtl/execute_branch_pipe.sv
// Branch-resolution stage for the MIST32 execute path: resolves target and condition,
// checks the fetch prediction, tracks the HALT run state and counts mispredicts.
module execute_branch_pipe #(
  parameter int P_ADDR_N = 32,
  parameter int P_CNT_N  = 16
)(
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                iRESET_SYNC,
  input  logic                iVALID,
  output logic                oBUSY,
  input  logic [4:0]          iCMD,
  input  logic [3:0]          iCC,
  input  logic [4:0]          iFLAG,
  input  logic [P_ADDR_N-1:0] iPC,
  input  logic [P_ADDR_N-1:0] iDATA_1,
  input  logic                iPREDICT_TAKEN,
  input  logic [P_ADDR_N-1:0] iPREDICT_ADDR,
  input  logic                iRESTART,
  input  logic                iCOUNT_CLEAR,
  output logic                oVALID,
  input  logic                iBUSY,
  output logic [P_ADDR_N-1:0] oBRANCH_ADDR,
  output logic                oJUMP_VALID,
  output logic                oNOT_JUMP_VALID,
  output logic                oIB_VALID,
  output logic                oIDTS_VALID,
  output logic                oHALT_VALID,
  output logic                oMISPREDICT,
  output logic [P_ADDR_N-1:0] oFLUSH_ADDR,
  output logic                oHALTED,
  output logic [P_CNT_N-1:0]  oMISS_COUNT
);

  localparam logic [4:0] L_CMD_BUR  = 5'h00;
  localparam logic [4:0] L_CMD_BR   = 5'h01;
  localparam logic [4:0] L_CMD_B    = 5'h02;
  localparam logic [4:0] L_CMD_INTB = 5'h03;
  localparam logic [4:0] L_CMD_IDTS = 5'h04;
  localparam logic [4:0] L_CMD_HALT = 5'h06;

  localparam logic [3:0] L_CC_AL  = 4'h0;
  localparam logic [3:0] L_CC_EQ  = 4'h1;
  localparam logic [3:0] L_CC_NEQ = 4'h2;
  localparam logic [3:0] L_CC_MI  = 4'h3;
  localparam logic [3:0] L_CC_PL  = 4'h4;
  localparam logic [3:0] L_CC_EN  = 4'h5;
  localparam logic [3:0] L_CC_ON  = 4'h6;
  localparam logic [3:0] L_CC_OVF = 4'h7;
  localparam logic [3:0] L_CC_UEO = 4'h8;
  localparam logic [3:0] L_CC_UU  = 4'h9;
  localparam logic [3:0] L_CC_UO  = 4'ha;
  localparam logic [3:0] L_CC_UEU = 4'hb;
  localparam logic [3:0] L_CC_SEO = 4'hc;
  localparam logic [3:0] L_CC_SU  = 4'hd;
  localparam logic [3:0] L_CC_SO  = 4'he;
  localparam logic [3:0] L_CC_SEU = 4'hf;

  localparam int L_FLAG_ZF = 0;
  localparam int L_FLAG_PF = 1;
  localparam int L_FLAG_CF = 2;
  localparam int L_FLAG_OF = 3;
  localparam int L_FLAG_SF = 4;

  localparam logic [P_ADDR_N-1:0] L_FOUR = P_ADDR_N'(4);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Handshake: a command is taken when iVALID && !oBUSY. A presented result is consumed
  // on any edge where iBUSY is low; while iBUSY is high it is held and nothing is taken.
  state_t                r_state;
  state_t                w_state_next;
  logic                  r_valid;
  logic [P_ADDR_N-1:0]   r_branch_addr;
  logic                  r_jump;
  logic                  r_not_jump;
  logic                  r_ib;
  logic                  r_idts;
  logic                  r_halt;
  logic                  r_mispredict;
  logic [P_ADDR_N-1:0]   r_flush_addr;
  logic [P_CNT_N-1:0]    r_count;

  logic                  w_accept;
  logic                  w_busy;
  logic [P_ADDR_N-1:0]   w_pc_next;
  logic [P_ADDR_N-1:0]   w_target;
  logic                  w_taken;
  logic                  w_zf, w_pf, w_cf, w_of, w_sf, w_lt;
  logic                  w_jump;
  logic                  w_not_jump;
  logic                  w_ib;
  logic                  w_idts;
  logic                  w_halt;
  logic                  w_mispredict;
  logic [P_ADDR_N-1:0]   w_flush_addr;

  assign w_busy   = (r_state == ST_HALTED) || (r_valid && iBUSY);
  assign w_accept = iVALID && !w_busy;

  assign w_pc_next = iPC + L_FOUR;

  always_comb begin
    w_target = '0;
    case (iCMD)
      L_CMD_BUR, L_CMD_BR: w_target = iDATA_1 + iPC;
      L_CMD_B:             w_target = iDATA_1;
      L_CMD_IDTS:          w_target = w_pc_next;
      default:             w_target = '0;
    endcase
  end

  assign w_zf = iFLAG[L_FLAG_ZF];
  assign w_pf = iFLAG[L_FLAG_PF];
  assign w_cf = iFLAG[L_FLAG_CF];
  assign w_of = iFLAG[L_FLAG_OF];
  assign w_sf = iFLAG[L_FLAG_SF];
  assign w_lt = w_sf ^ w_of;

  always_comb begin
    w_taken = 1'b1;
    case (iCC)
      L_CC_AL:  w_taken = 1'b1;
      L_CC_EQ:  w_taken = w_zf;
      L_CC_NEQ: w_taken = !w_zf;
      L_CC_MI:  w_taken = w_sf;
      L_CC_PL:  w_taken = !w_sf;
      L_CC_EN:  w_taken = !w_pf;
      L_CC_ON:  w_taken = w_pf;
      L_CC_OVF: w_taken = w_of;
      L_CC_UEO: w_taken = w_cf;
      L_CC_UU:  w_taken = !w_cf;
      L_CC_UO:  w_taken = w_cf && !w_zf;
      L_CC_UEU: w_taken = !w_cf || w_zf;
      L_CC_SEO: w_taken = !w_lt;
      L_CC_SU:  w_taken = w_lt;
      L_CC_SO:  w_taken = !(w_lt || w_zf);
      L_CC_SEU: w_taken = w_lt || w_zf;
      default:  w_taken = 1'b1;
    endcase
  end

  // Interrupt-class commands always redirect fetch; HALT never does.
  always_comb begin
    w_jump       = 1'b0;
    w_not_jump   = 1'b0;
    w_ib         = 1'b0;
    w_idts       = 1'b0;
    w_halt       = 1'b0;
    w_mispredict = 1'b0;
    w_flush_addr = w_pc_next;
    case (iCMD)
      L_CMD_INTB: begin
        w_ib         = 1'b1;
        w_mispredict = 1'b1;
        w_flush_addr = w_target;
      end
      L_CMD_IDTS: begin
        w_idts       = 1'b1;
        w_mispredict = 1'b1;
        w_flush_addr = w_target;
      end
      L_CMD_HALT: begin
        w_halt = 1'b1;
      end
      default: begin
        w_jump       = w_taken;
        w_not_jump   = !w_taken;
        w_mispredict = (w_taken != iPREDICT_TAKEN) ||
                       (w_taken && (w_target != iPREDICT_ADDR));
        w_flush_addr = w_taken ? w_target : w_pc_next;
      end
    endcase
  end

  // A restart arriving with the HALT accept is dropped: the FSM is still in RUN then.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:    if (w_accept && w_halt) w_state_next = ST_HALTED;
      ST_HALTED: if (iRESTART)           w_state_next = ST_RUN;
      default:   w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state <= ST_RUN;
    end else if (iRESET_SYNC) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_valid       <= 1'b0;
      r_branch_addr <= '0;
      r_jump        <= 1'b0;
      r_not_jump    <= 1'b0;
      r_ib          <= 1'b0;
      r_idts        <= 1'b0;
      r_halt        <= 1'b0;
      r_mispredict  <= 1'b0;
      r_flush_addr  <= '0;
    end else if (iRESET_SYNC) begin
      r_valid       <= 1'b0;
      r_branch_addr <= '0;
      r_jump        <= 1'b0;
      r_not_jump    <= 1'b0;
      r_ib          <= 1'b0;
      r_idts        <= 1'b0;
      r_halt        <= 1'b0;
      r_mispredict  <= 1'b0;
      r_flush_addr  <= '0;
    end else if (w_accept) begin
      r_valid       <= 1'b1;
      r_branch_addr <= w_target;
      r_jump        <= w_jump;
      r_not_jump    <= w_not_jump;
      r_ib          <= w_ib;
      r_idts        <= w_idts;
      r_halt        <= w_halt;
      r_mispredict  <= w_mispredict;
      r_flush_addr  <= w_flush_addr;
    end else if (!iBUSY) begin
      r_valid <= 1'b0;
    end
  end

  // Saturating count; a clear wins over a same-cycle increment.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_count <= '0;
    end else if (iRESET_SYNC || iCOUNT_CLEAR) begin
      r_count <= '0;
    end else if (w_accept && w_mispredict && (r_count != {P_CNT_N{1'b1}})) begin
      r_count <= r_count + P_CNT_N'(1);
    end
  end

  assign oBUSY           = w_busy;
  assign oVALID          = r_valid;
  assign oBRANCH_ADDR    = r_branch_addr;
  assign oJUMP_VALID     = r_jump;
  assign oNOT_JUMP_VALID = r_not_jump;
  assign oIB_VALID       = r_ib;
  assign oIDTS_VALID     = r_idts;
  assign oHALT_VALID     = r_halt;
  assign oMISPREDICT     = r_mispredict;
  assign oFLUSH_ADDR     = r_flush_addr;
  assign oHALTED         = (r_state == ST_HALTED);
  assign oMISS_COUNT     = r_count;

endmodule

// File: tb/tb_execute_branch_pipe.sv
// Scoreboard bench for execute_branch_pipe: a behavioural model queues expected results,
// a monitor compares every presented result; directed cases then randomized traffic.
module tb_execute_branch_pipe;

  localparam int AW = 32;
  localparam int CW = 2;

  localparam logic [4:0] BUR = 5'h00, BR = 5'h01, B = 5'h02, INTB = 5'h03,
                         IDTS = 5'h04, NOP = 5'h05, HALT = 5'h06;
  localparam logic [3:0] CC_AL = 4'h0, CC_EQ = 4'h1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [AW-1:0] flush;
    logic          jump;
    logic          not_jump;
    logic          ib;
    logic          idts;
    logic          halt;
    logic          mp;
    logic [CW-1:0] cnt;
  } res_t;

  localparam int EXP_W = $bits(res_t);

  logic          iCLOCK, inRESET, iRESET_SYNC, iVALID, oBUSY;
  logic [4:0]    iCMD;
  logic [3:0]    iCC;
  logic [4:0]    iFLAG;
  logic [AW-1:0] iPC, iDATA_1, iPREDICT_ADDR, oBRANCH_ADDR, oFLUSH_ADDR;
  logic          iPREDICT_TAKEN, iRESTART, iCOUNT_CLEAR, oVALID, iBUSY;
  logic          oJUMP_VALID, oNOT_JUMP_VALID, oIB_VALID, oIDTS_VALID, oHALT_VALID;
  logic          oMISPREDICT, oHALTED;
  logic [CW-1:0] oMISS_COUNT;

  execute_branch_pipe #(.P_ADDR_N(AW), .P_CNT_N(CW)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iVALID(iVALID), .oBUSY(oBUSY), .iCMD(iCMD), .iCC(iCC), .iFLAG(iFLAG),
    .iPC(iPC), .iDATA_1(iDATA_1), .iPREDICT_TAKEN(iPREDICT_TAKEN),
    .iPREDICT_ADDR(iPREDICT_ADDR), .iRESTART(iRESTART), .iCOUNT_CLEAR(iCOUNT_CLEAR),
    .oVALID(oVALID), .iBUSY(iBUSY), .oBRANCH_ADDR(oBRANCH_ADDR),
    .oJUMP_VALID(oJUMP_VALID), .oNOT_JUMP_VALID(oNOT_JUMP_VALID),
    .oIB_VALID(oIB_VALID), .oIDTS_VALID(oIDTS_VALID), .oHALT_VALID(oHALT_VALID),
    .oMISPREDICT(oMISPREDICT), .oFLUSH_ADDR(oFLUSH_ADDR), .oHALTED(oHALTED),
    .oMISS_COUNT(oMISS_COUNT)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [EXP_W-1:0] exp_q[$];
  int unsigned m_cnt = 0;
  bit m_halted = 0;
  int busy_mode = 0;  // 0 low, 1 high, 2 random

  // ---------------- clock / reset ----------------
  initial begin
    iCLOCK = 0;
    forever #5 iCLOCK = ~iCLOCK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iBUSY = 0;
    forever begin
      @(posedge iCLOCK);
      #2;
      case (busy_mode)
        0: iBUSY = 0;
        1: iBUSY = 1;
        default: iBUSY = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  task automatic check(input string nm, input logic [EXP_W-1:0] a_v, input logic [EXP_W-1:0] e_v);
    n_tests++;
    if (a_v !== e_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a_v, e_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic cond(input logic [3:0] cc, input logic [4:0] fl);
    logic zf, pf, cf, ovf, sf, less;
    zf = fl[0]; pf = fl[1]; cf = fl[2]; ovf = fl[3]; sf = fl[4];
    less = (sf != ovf);
    case (cc)
      4'h0: return 1'b1;
      4'h1: return zf;
      4'h2: return !zf;
      4'h3: return sf;
      4'h4: return !sf;
      4'h5: return !pf;
      4'h6: return pf;
      4'h7: return ovf;
      4'h8: return cf;
      4'h9: return !cf;
      4'ha: return cf && !zf;
      4'hb: return !cf || zf;
      4'hc: return !less;
      4'hd: return less;
      4'he: return !(less || zf);
      default: return less || zf;
    endcase
  endfunction

  function automatic res_t model(input logic [4:0] cmd, input logic [3:0] cc, input logic [4:0] fl,
                                 input logic [AW-1:0] pc, input logic [AW-1:0] d1,
                                 input logic pt, input logic [AW-1:0] pa);
    res_t r;
    logic tk;
    r = '0;
    tk = cond(cc, fl);
    if (cmd == BUR || cmd == BR) r.addr = d1 + pc;
    else if (cmd == B)           r.addr = d1;
    else if (cmd == IDTS)        r.addr = pc + 32'd4;
    else                         r.addr = '0;
    if (cmd == INTB || cmd == IDTS) begin
      r.ib = (cmd == INTB);
      r.idts = (cmd == IDTS);
      r.mp = 1;
      r.flush = r.addr;
    end else if (cmd == HALT) begin
      r.halt = 1;
    end else begin
      r.jump = tk;
      r.not_jump = !tk;
      r.mp = (tk != pt) || (tk && r.addr != pa);
      r.flush = tk ? r.addr : pc + 32'd4;
    end
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    res_t act, e;
    forever begin
      @(negedge iCLOCK);
      if (inRESET && oVALID) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got addr %h with nothing expected", oBRANCH_ADDR);
        end else begin
          e = res_t'(exp_q[0]);
          act.addr = oBRANCH_ADDR;   act.flush = oFLUSH_ADDR;
          act.jump = oJUMP_VALID;    act.not_jump = oNOT_JUMP_VALID;
          act.ib = oIB_VALID;        act.idts = oIDTS_VALID;
          act.halt = oHALT_VALID;    act.mp = oMISPREDICT;
          act.cnt = oMISS_COUNT;
          if (e.halt) act.flush = e.flush;
          check("result", act, e);
          if (!iBUSY) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [4:0] cmd, input logic [3:0] cc, input logic [4:0] fl,
                      input logic [AW-1:0] pc, input logic [AW-1:0] d1,
                      input logic pt, input logic [AW-1:0] pa, input logic clr, input logic rst_req);
    int budget;
    res_t e;
    iVALID = 1; iCMD = cmd; iCC = cc; iFLAG = fl; iPC = pc; iDATA_1 = d1;
    iPREDICT_TAKEN = pt; iPREDICT_ADDR = pa;
    budget = 0;
    forever begin
      @(negedge iCLOCK);
      if (!oBUSY) break;
      budget++;
      if (budget > 60) break;
    end
    if (budget > 60) begin
      check("accept_timeout", 1, 0);
      iVALID = 0;
    end else begin
      iCOUNT_CLEAR = clr;
      iRESTART = rst_req;
      e = model(cmd, cc, fl, pc, d1, pt, pa);
      if (clr) m_cnt = 0;
      else if (e.mp && m_cnt != 3) m_cnt++;
      e.cnt = CW'(m_cnt);
      if (cmd == HALT) m_halted = 1;
      exp_q.push_back(EXP_W'(e));
      @(posedge iCLOCK);
      #1;
      iVALID = 0; iCOUNT_CLEAR = 0; iRESTART = 0;
      check("latency_valid", EXP_W'(oVALID), 1);
      if (cmd == HALT) begin
        check("halted_after_halt", EXP_W'(oHALTED), 1);
        check("busy_after_halt", EXP_W'(oBUSY), 1);
      end
    end
  endtask

  task automatic restart(input int wait_cycles);
    repeat (wait_cycles) @(posedge iCLOCK);
    #1;
    iRESTART = 1;
    @(posedge iCLOCK);
    #1;
    iRESTART = 0;
    m_halted = 0;
    check("halted_after_restart", EXP_W'(oHALTED), 0);
  endtask

  task automatic drain();
    int budget;
    busy_mode = 0;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(posedge iCLOCK);
      budget++;
    end
    check("drain_empty", EXP_W'(exp_q.size()), 0);
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_valid"}, EXP_W'(oVALID), 0);
    check({nm, "_busy"}, EXP_W'(oBUSY), 0);
    check({nm, "_addrs"}, EXP_W'({oBRANCH_ADDR, oFLUSH_ADDR}), 0);
    check({nm, "_class"}, EXP_W'({oJUMP_VALID, oNOT_JUMP_VALID, oIB_VALID, oIDTS_VALID,
                                 oHALT_VALID, oMISPREDICT}), 0);
    check({nm, "_halted"}, EXP_W'(oHALTED), 0);
    check({nm, "_count"}, EXP_W'(oMISS_COUNT), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    inRESET = 0; iRESET_SYNC = 0; iVALID = 0; iCMD = 0; iCC = 0; iFLAG = 0;
    iPC = 0; iDATA_1 = 0; iPREDICT_TAKEN = 0; iPREDICT_ADDR = 0;
    iRESTART = 0; iCOUNT_CLEAR = 0;
    repeat (3) @(posedge iCLOCK);
    #1;
    check_all_zero("reset");
    inRESET = 1;
    @(posedge iCLOCK);
    #1;

    // Directed branch cases
    send(BR, CC_EQ, 5'b00001, 32'h100, 32'h20, 1, 32'h120, 0, 0);
    check("dir_taken_addr", EXP_W'({oJUMP_VALID, oMISPREDICT, oBRANCH_ADDR}), EXP_W'({2'b10, 32'h120}));
    check("dir_count0", EXP_W'(oMISS_COUNT), 0);
    send(BR, CC_EQ, 5'b00000, 32'h100, 32'h20, 1, 32'h120, 0, 0);
    check("dir_not_taken", EXP_W'({oNOT_JUMP_VALID, oMISPREDICT, oFLUSH_ADDR}), EXP_W'({2'b11, 32'h104}));
    check("dir_count1", EXP_W'(oMISS_COUNT), 1);
    send(BR, CC_EQ, 5'b00001, 32'h100, 32'h20, 1, 32'h124, 0, 0);
    check("dir_bad_target", EXP_W'({oMISPREDICT, oFLUSH_ADDR}), EXP_W'({1'b1, 32'h120}));
    send(IDTS, CC_AL, 5'b00000, 32'hFFFF_FFFC, 32'h0, 0, 32'h0, 0, 0);
    check("dir_idts_wrap", EXP_W'({oIDTS_VALID, oMISPREDICT, oBRANCH_ADDR}), EXP_W'({2'b11, 32'h0}));
    check("dir_count3", EXP_W'(oMISS_COUNT), 3);
    for (int i = 0; i < 5; i++) send(INTB, CC_AL, 5'b0, 32'h40 * i, 32'h0, 0, 32'h0, 0, 0);
    check("dir_saturate", EXP_W'(oMISS_COUNT), 3);
    send(INTB, CC_AL, 5'b0, 32'h200, 32'h0, 0, 32'h0, 1, 0);
    check("dir_clear_prio", EXP_W'(oMISS_COUNT), 0);
    send(B, CC_AL, 5'b0, 32'h300, 32'h8000, 1, 32'h8000, 0, 0);
    drain();

    // Downstream stall with a second command waiting
    send(BUR, CC_AL, 5'b0, 32'h1000, 32'h10, 0, 32'h0, 0, 0);
    busy_mode = 1;
    fork
      send(B, CC_EQ, 5'b00000, 32'h2000, 32'h4444, 0, 32'h0, 0, 0);
      begin
        repeat (3) begin
          @(negedge iCLOCK);
          check("stall_busy", EXP_W'(oBUSY), 1);
        end
        busy_mode = 0;
      end
    join
    drain();

    // HALT: restart in the accept cycle is ignored, inputs ignored while halted
    send(HALT, CC_AL, 5'b0, 32'h500, 32'h0, 0, 32'h0, 0, 1);
    drain();
    iVALID = 1; iCMD = B; iDATA_1 = 32'hDEAD;
    repeat (3) begin
      @(negedge iCLOCK);
      check("halted_busy", EXP_W'({oBUSY, oHALTED}), 2'b11);
    end
    iVALID = 0;
    restart(0);
    check("restart_busy", EXP_W'(oBUSY), 0);
    send(BR, CC_AL, 5'b0, 32'h600, 32'h4, 1, 32'h604, 0, 0);
    drain();

    // Randomized traffic
    busy_mode = 2;
    for (int n = 0; n < 300; n++) begin
      logic [4:0] cmd;
      logic [AW-1:0] pc, d1, pa;
      logic [3:0] cc;
      logic [4:0] fl;
      logic pt;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 6) cmd = 5'(sel);
      else cmd = 5'($urandom_range(7, 31));
      pc = $urandom; d1 = $urandom;
      cc = 4'($urandom_range(0, 15));
      fl = 5'($urandom_range(0, 31));
      pt = 1'($urandom_range(0, 1));
      pa = ($urandom_range(0, 1) == 1) ? model(cmd, cc, fl, pc, d1, pt, 0).addr : $urandom;
      send(cmd, cc, fl, pc, d1, pt, pa, ($urandom_range(0, 7) == 0), 0);
      if (cmd == HALT) restart($urandom_range(0, 4));
    end
    drain();

    // Synchronous clear while a result is held
    busy_mode = 1;
    send(INTB, CC_AL, 5'b0, 32'h700, 32'h0, 0, 32'h0, 0, 0);
    @(negedge iCLOCK);
    iRESET_SYNC = 1;
    @(posedge iCLOCK);
    #1;
    iRESET_SYNC = 0;
    exp_q.delete();
    m_cnt = 0;
    busy_mode = 0;
    @(posedge iCLOCK);
    #3;
    check_all_zero("sync_reset");

    // Asynchronous reset mid-stall
    busy_mode = 1;
    send(INTB, CC_AL, 5'b0, 32'h800, 32'h0, 0, 32'h0, 0, 0);
    #2;
    inRESET = 0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    m_cnt = 0;
    busy_mode = 0;
    @(negedge iCLOCK);
    inRESET = 1;
    @(posedge iCLOCK);
    #1;
    send(BR, CC_AL, 5'b0, 32'h900, 32'h10, 0, 32'h0, 0, 0);
    check("post_reset_count", EXP_W'(oMISS_COUNT), 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
